// File: rtl/mem_pkg.sv
// Shared constants and types for the memory arbiter slice.
package mem_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Successor of a client index, wrapping n-1 -> 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first requesting index at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  localparam int SW = PW + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rot   = N'({req, req} >> ptr);
    valid = |rot;
    sum   = '0;
    // Walk downwards so the lowest offset from ptr is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sum = SW'(i) + {1'b0, ptr};
    end
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one request/ack memory port among N clients;
// one transaction in flight, command latched on grant and held until mem_ack.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AN = ADDR_W,
  parameter int DN = DATA_W,
  parameter int N  = 4
) (
  input  logic                 clkSYS,
  input  logic                 n_reset,
  input  logic [N-1:0][AN-1:0] addr,
  input  logic [N-1:0][DN-1:0] data,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         wr,
  output logic [N-1:0]         ack,
  output logic [DN-1:0]        rdata,
  output logic [AN-1:0]        mem_addr,
  output logic [DN-1:0]        mem_data,
  output logic                 mem_req,
  output logic                 mem_wr,
  input  logic                 mem_ack,
  input  logic [DN-1:0]        mem_rdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BUSY;
            g        <= pick_idx;
            mem_addr <= addr[pick_idx];
            mem_data <= data[pick_idx];
            mem_wr   <= wr[pick_idx];
          end
        end
        BUSY: begin
          // The granted client's req is ignored here, so a dropped req still completes.
          if (mem_ack) begin
            state <= IDLE;
            ptr   <= PW'(next_idx(int'(g), N));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A direct decode of the state flop, so it falls with the async reset.
  assign mem_req = (state == BUSY);
  assign rdata   = mem_rdata;

  always_comb begin
    ack = '0;
    if (state == BUSY && mem_ack) ack[g] = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AN     = 24;
  localparam int DN     = 16;
  localparam int N      = 4;
  localparam int FILL_W = 4;
  localparam int FILL_N = 12;

  logic                 clkSYS = 1'b0;
  logic                 n_reset;
  logic [N-1:0][AN-1:0] addr;
  logic [N-1:0][DN-1:0] data;
  logic [N-1:0]         req;
  logic [N-1:0]         wr;
  logic [N-1:0]         ack;
  logic [DN-1:0]        rdata;
  logic [AN-1:0]        mem_addr;
  logic [DN-1:0]        mem_data;
  logic                 mem_req;
  logic                 mem_wr;
  logic                 mem_ack;
  logic [DN-1:0]        mem_rdata;

  mem_arbiter #(.AN(AN), .DN(DN), .N(N)) dut (
    .clkSYS    (clkSYS),
    .n_reset   (n_reset),
    .addr      (addr),
    .data      (data),
    .req       (req),
    .wr        (wr),
    .ack       (ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clkSYS = ~clkSYS;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the arbiter.
  bit            m_busy;
  int            m_g, m_ptr, m_cnt, m_lat, m_done;
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_data;
  logic          m_wr;

  // Memory responder knobs.
  bit            spurious, lat_rand, fix_rdata;
  int            fix_lat;
  logic [DN-1:0] fix_rdata_val;

  // Observations of the DUT.
  logic          obs_mem_req;
  logic [N-1:0]  obs_ack;
  int            ack_cnt[N];
  int            ack_total;
  int            ack_log[$];
  bit            ack_new;
  int            last_ack_idx;
  logic [N-1:0]  last_ack_vec;
  logic [AN-1:0] last_ack_addr;
  logic [DN-1:0] last_ack_data;
  logic          last_ack_wr;
  logic [DN-1:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_g    = 0;
    m_cnt  = 0;
    m_addr = '0;
    m_data = '0;
    m_wr   = 1'b0;
  endtask

  function automatic logic [AN-1:0] fill_addr(input int i);
    return 24'h010000 + AN'(i % FILL_W) + AN'(i / FILL_W) * 24'h000100;
  endfunction

  function automatic logic [DN-1:0] fill_data(input int i);
    return 16'hF000 + DN'(i * 3);
  endfunction

  // One clock cycle: drive memory side, check outputs, advance model, cross the edge.
  task automatic tick();
    logic         do_ack;
    logic [N-1:0] exp_ack;
    logic [N-1:0] clr;
    int           w;
    do_ack    = (m_busy && m_cnt == m_lat) || (!m_busy && spurious);
    mem_ack   = do_ack;
    mem_rdata = fix_rdata ? fix_rdata_val : DN'($urandom);
    #1;
    exp_ack = '0;
    if (m_busy && do_ack) exp_ack[m_g] = 1'b1;
    check("mem_req",  mem_req,  m_busy);
    check("mem_addr", mem_addr, m_addr);
    check("mem_data", mem_data, m_data);
    check("mem_wr",   mem_wr,   m_wr);
    check("ack",      ack,      exp_ack);
    check("rdata",    rdata,    mem_rdata);
    obs_mem_req = mem_req;
    obs_ack     = ack;
    ack_new     = (ack != '0);
    if (ack_new) begin
      for (int i = 0; i < N; i++) if (ack[i]) last_ack_idx = i;
      ack_cnt[last_ack_idx]++;
      ack_total++;
      ack_log.push_back(last_ack_idx);
      last_ack_vec  = ack;
      last_ack_addr = mem_addr;
      last_ack_data = mem_data;
      last_ack_wr   = mem_wr;
      last_rdata    = rdata;
    end
    clr = '0;
    if (!m_busy) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      if (w >= 0) begin
        m_busy = 1'b1;
        m_g    = w;
        m_addr = addr[w];
        m_data = data[w];
        m_wr   = wr[w];
        m_cnt  = 1;
        m_lat  = lat_rand ? int'($urandom_range(1, 4)) : fix_lat;
      end
    end else if (do_ack) begin
      m_busy = 1'b0;
      m_ptr  = (m_g + 1) % N;
      m_done++;
      clr[m_g] = 1'b1;
    end else begin
      m_cnt++;
    end
    @(posedge clkSYS);
    #1;
    mem_ack = 1'b0;
    req     = req & ~clr;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && (m_busy || req != '0); c++) tick();
    check({tag, "_drain"}, (m_busy || req != '0), 0);
  endtask

  task automatic do_reset(input string tag);
    n_reset = 1'b0;
    #1;
    check({tag, "_mem_req"},  mem_req,  0);
    check({tag, "_ack"},      ack,      0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_mem_wr"},   mem_wr,   0);
    mem_ack = 1'b0;
    model_reset();
    @(posedge clkSYS);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int issued1, issued3, got1;
    bit rereq;
    int order_a[5];
    int order_b[3];
    order_a = '{0, 1, 2, 3, 0};
    order_b = '{0, 2, 3};

    n_reset = 1'b0;
    req = '0; wr = '0; addr = '0; data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    spurious = 1'b0; lat_rand = 1'b0; fix_rdata = 1'b0; fix_lat = 3;
    fix_rdata_val = '0; m_done = 0; ack_total = 0; last_ack_idx = 0;
    foreach (ack_cnt[i]) ack_cnt[i] = 0;
    model_reset();
    do_reset("por");

    // Client 0 write, memory latency 3.
    base = ack_cnt[0];
    addr[0] = 24'h001234; data[0] = 16'hBEEF; wr[0] = 1'b1; req[0] = 1'b1;
    tick();
    check("w0_req_same_cycle", obs_mem_req, 0);
    tick();
    check("w0_req_next_cycle", obs_mem_req, 1);
    drain("w0");
    check("w0_ack_count", ack_cnt[0] - base, 1);
    check("w0_addr", last_ack_addr, 24'h001234);
    check("w0_data", last_ack_data, 16'hBEEF);
    check("w0_wr",   last_ack_wr,   1);

    // Client 2 read with fixed read data.
    addr[2] = 24'h00ABCD; wr[2] = 1'b0; req[2] = 1'b1;
    fix_rdata = 1'b1; fix_rdata_val = 16'h5A5A;
    drain("rd2");
    fix_rdata = 1'b0;
    check("rd2_rdata", last_rdata, 16'h5A5A);
    check("rd2_ack_vec", last_ack_vec, 4'b0100);

    // Spurious mem_ack while idle.
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    check("spur_ack", obs_ack, 0);
    tick();
    check("spur_stay_idle", obs_mem_req, 0);

    // All four request together from reset; client 0 re-requests after its ack.
    do_reset("r037");
    ack_log.delete();
    fix_lat = 2;
    for (int k = 0; k < N; k++) begin
      addr[k] = 24'h100000 + AN'(k);
      data[k] = 16'h1100 + DN'(k);
      wr[k]   = 1'(k % 2);
    end
    req = '1;
    rereq = 1'b0;
    for (int c = 0; c < 200 && ack_log.size() < 5; c++) begin
      tick();
      if (!rereq && !req[0]) begin
        addr[0] = 24'h100010; req[0] = 1'b1; rereq = 1'b1;
      end
    end
    drain("r037");
    check("order_len", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) check("order_rr", ack_log[i], order_a[i]);

    // Reset in the middle of a transaction.
    req[2] = 1'b1; addr[2] = 24'h002000;
    drain("pre040");
    fix_lat = 6;
    req[2] = 1'b1; addr[2] = 24'h002222; data[2] = 16'h2222; wr[2] = 1'b1;
    tick(); tick(); tick();
    check("r040_busy", obs_mem_req, 1);
    base = ack_cnt[2];
    addr[0] = 24'h003000; req[0] = 1'b1;
    addr[3] = 24'h003333; req[3] = 1'b1;
    ack_log.delete();
    mem_ack = 1'b1;
    do_reset("r040");
    check("r040_no_ack", ack_cnt[2] - base, 0);
    fix_lat = 2;
    drain("r040");
    check("r040_order_len", ack_log.size(), 3);
    for (int i = 0; i < 3 && i < ack_log.size(); i++) check("r040_order", ack_log[i], order_b[i]);
    check("r040_reissue_acked", ack_cnt[2] - base, 1);

    // Rectangle fill on client 1 streaming against client 3.
    ack_log.delete();
    lat_rand = 1'b1;
    issued1 = 0; issued3 = 0; got1 = 0;
    for (int c = 0; c < 400 && (got1 < FILL_N || m_busy || req != '0); c++) begin
      if (!req[1] && issued1 < FILL_N) begin
        addr[1] = fill_addr(issued1); data[1] = fill_data(issued1); wr[1] = 1'b1;
        req[1] = 1'b1; issued1++;
      end
      if (!req[3] && issued3 < FILL_N) begin
        addr[3] = AN'($urandom); data[3] = DN'($urandom); wr[3] = 1'b0;
        req[3] = 1'b1; issued3++;
      end
      tick();
      if (ack_new && last_ack_idx == 1) begin
        check("fill_addr", last_ack_addr, fill_addr(got1));
        check("fill_data", last_ack_data, fill_data(got1));
        got1++;
      end
    end
    check("fill_count", got1, FILL_N);
    for (int i = 1; i < ack_log.size(); i++)
      check("fill_alternate", ack_log[i], (ack_log[i-1] == 1) ? 3 : 1);

    // Randomized traffic with dropped requests and spurious acks.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          addr[k] = AN'($urandom); data[k] = DN'($urandom);
          wr[k] = 1'($urandom_range(0, 1)); req[k] = 1'b1;
        end
      end
      if (m_busy && $urandom_range(0, 15) == 0) req[m_g] = 1'b0;
      spurious = !m_busy && ($urandom_range(0, 9) == 0);
      tick();
    end
    spurious = 1'b0;
    drain("rand");
    check("total_acks", ack_total, m_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
